// File: rtl/mannix_mem_pkg.sv
// Shared types and helpers for the memory burst arbiter.
//   arb_state_e : burst FSM states
//   arb_mode_e  : arbitration policy selector
//   lane_mask() : final-beat lane-valid mask from (valid lanes - 1)
package mannix_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Widest lane mask the helper can produce; callers truncate to their lane count.
    localparam int unsigned MASK_MAX_W = 64;

    // Lanes 0..last_valid set, all others clear.
    function automatic logic [MASK_MAX_W-1:0] lane_mask(input int unsigned last_valid);
        if (last_valid >= MASK_MAX_W - 1) begin
            return '1;
        end
        return (MASK_MAX_W'(1) << (last_valid + 1)) - MASK_MAX_W'(1);
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner select for the burst arbiter.
//   req       : per-client request vector
//   prio      : high-priority class (fixed mode only)
//   mode      : fixed priority or round-robin
//   ptr       : round-robin start index (must be < NUM_CLIENTS)
//   win       : one-hot winner
//   win_idx   : winner index
//   win_valid : at least one request present
module mem_arb_picker
    import mannix_mem_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 5,
    localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [NUM_CLIENTS-1:0] prio,
    input  arb_mode_e              mode,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_CLIENTS-1:0] win,
    output logic [IDX_W-1:0]       win_idx,
    output logic                   win_valid
);

    always_comb begin
        logic [NUM_CLIENTS-1:0] cand;
        int unsigned            idx;
        win       = '0;
        win_idx   = '0;
        win_valid = 1'b0;
        cand      = '0;
        idx       = 0;
        if (mode == ARB_RR) begin
            // First requester at or after ptr, scanning circularly.
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                idx = 32'(ptr) + i;
                if (idx >= NUM_CLIENTS) begin
                    idx = idx - NUM_CLIENTS;
                end
                if (!win_valid && req[IDX_W'(idx)]) begin
                    win_valid = 1'b1;
                    win_idx   = IDX_W'(idx);
                end
            end
        end else begin
            // High-priority class wins if any of it is requesting; lowest index within the class.
            cand = ((req & prio) != '0) ? (req & prio) : req;
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                if (!win_valid && cand[IDX_W'(i)]) begin
                    win_valid = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end
        if (win_valid) begin
            win = NUM_CLIENTS'(1) << win_idx;
        end
    end

endmodule

// File: rtl/mem_burst_arbiter.sv
// N-client read-burst arbiter in front of a single memory read port.
//   clk, rst                 : clock, synchronous active-high reset
//   arb_mode, client_prio    : arbitration policy, fixed-mode priority class
//   cl_req/addr/len/last_valid : per-client burst requests (flattened vectors)
//   cl_gnt                   : one-cycle one-hot grant
//   cl_rvalid/rdata/rlast/rlane_en : return beats routed to the burst owner
//   mem_req/addr/ready       : address channel toward memory
//   mem_rvalid/rdata         : in-order read returns from memory
//   busy, err_stray          : burst in flight, return with nothing outstanding
module mem_burst_arbiter
    import mannix_mem_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 5,
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned DATA_W      = 256,
    parameter int unsigned NUM_LANES   = 16,
    parameter int unsigned MAX_BURST   = 16,
    localparam int unsigned LEN_W  = $clog2(MAX_BURST),
    localparam int unsigned LANE_W = $clog2(NUM_LANES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          arb_mode,
    input  logic [NUM_CLIENTS-1:0]        client_prio,
    input  logic [NUM_CLIENTS-1:0]        cl_req,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
    input  logic [NUM_CLIENTS*LEN_W-1:0]  cl_len,
    input  logic [NUM_CLIENTS*LANE_W-1:0] cl_last_valid,
    output logic [NUM_CLIENTS-1:0]        cl_gnt,
    output logic [NUM_CLIENTS-1:0]        cl_rvalid,
    output logic [DATA_W-1:0]             cl_rdata,
    output logic                          cl_rlast,
    output logic [NUM_LANES-1:0]          cl_rlane_en,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ready,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          busy,
    output logic                          err_stray
);

    localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int unsigned CNT_W = LEN_W + 1;

    arb_state_e         state_q;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner_q;
    logic [LEN_W-1:0]   len_q;
    logic [LANE_W-1:0]  last_valid_q;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   ret_cnt;

    logic [NUM_CLIENTS-1:0] win;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_valid;
    logic                   beat_pending;

    mem_arb_picker #(
        .NUM_CLIENTS (NUM_CLIENTS)
    ) u_picker (
        .req       (cl_req),
        .prio      (client_prio),
        .mode      (arb_mode_e'(arb_mode)),
        .ptr       (rr_ptr),
        .win       (win),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    // A return is legitimate only while fewer beats have come back than were issued.
    assign beat_pending = (ret_cnt != issue_cnt);

    // Burst FSM, counters, latched context and return register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr       <= '0;
            owner_q      <= '0;
            len_q        <= '0;
            last_valid_q <= '0;
            issue_cnt    <= '0;
            ret_cnt      <= '0;
            cl_gnt       <= '0;
            cl_rvalid    <= '0;
            cl_rdata     <= '0;
            cl_rlast     <= 1'b0;
            cl_rlane_en  <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            busy         <= 1'b0;
            err_stray    <= 1'b0;
        end else begin
            cl_gnt      <= '0;
            cl_rvalid   <= '0;
            cl_rlast    <= 1'b0;
            cl_rlane_en <= '0;
            err_stray   <= 1'b0;

            // Return path runs in every state; strays are dropped without touching the FSM.
            if (mem_rvalid) begin
                if (beat_pending) begin
                    cl_rvalid <= NUM_CLIENTS'(1) << owner_q;
                    cl_rdata  <= mem_rdata;
                    ret_cnt   <= ret_cnt + 1'b1;
                    if (ret_cnt == {1'b0, len_q}) begin
                        cl_rlast    <= 1'b1;
                        cl_rlane_en <= NUM_LANES'(lane_mask(32'(last_valid_q)));
                    end else begin
                        cl_rlane_en <= '1;
                    end
                end else begin
                    err_stray <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        cl_gnt       <= win;
                        mem_req      <= 1'b1;
                        mem_addr     <= cl_addr[win_idx*ADDR_W +: ADDR_W];
                        len_q        <= cl_len[win_idx*LEN_W +: LEN_W];
                        last_valid_q <= cl_last_valid[win_idx*LANE_W +: LANE_W];
                        owner_q      <= win_idx;
                        issue_cnt    <= '0;
                        ret_cnt      <= '0;
                        busy         <= 1'b1;
                        state_q      <= ISSUE;
                        if (arb_mode_e'(arb_mode) == ARB_RR) begin
                            rr_ptr <= (win_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : win_idx + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // Address advances only on acceptance, so it holds through stalls.
                    if (mem_ready) begin
                        mem_addr  <= mem_addr + 1'b1;
                        issue_cnt <= issue_cnt + 1'b1;
                        if (issue_cnt == {1'b0, len_q}) begin
                            mem_req <= 1'b0;
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_rvalid && beat_pending && (ret_cnt == {1'b0, len_q})) begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Scoreboard bench for mem_burst_arbiter: stimulus pushes expected grants, addresses
// and return beats; a memory responder and an output monitor pop and compare.
module tb_mem_burst_arbiter;

    localparam int N  = 5;
    localparam int AW = 19;
    localparam int DW = 256;
    localparam int NL = 16;
    localparam int LW = 4;

    typedef struct packed {
        logic [N-1:0]  rv;
        logic [DW-1:0] d;
        logic          last;
        logic [NL-1:0] lane;
    } ret_t;

    logic            clk;
    logic            rst;
    logic            arb_mode;
    logic [N-1:0]    client_prio;
    logic [N-1:0]    cl_req;
    logic [N*AW-1:0] cl_addr;
    logic [N*LW-1:0] cl_len;
    logic [N*LW-1:0] cl_last_valid;
    logic [N-1:0]    cl_gnt;
    logic [N-1:0]    cl_rvalid;
    logic [DW-1:0]   cl_rdata;
    logic            cl_rlast;
    logic [NL-1:0]   cl_rlane_en;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_ready;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;
    logic            busy;
    logic            err_stray;

    mem_burst_arbiter #(
        .NUM_CLIENTS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .NUM_LANES   (NL),
        .MAX_BURST   (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arb_mode      (arb_mode),
        .client_prio   (client_prio),
        .cl_req        (cl_req),
        .cl_addr       (cl_addr),
        .cl_len        (cl_len),
        .cl_last_valid (cl_last_valid),
        .cl_gnt        (cl_gnt),
        .cl_rvalid     (cl_rvalid),
        .cl_rdata      (cl_rdata),
        .cl_rlast      (cl_rlast),
        .cl_rlane_en   (cl_rlane_en),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .err_stray     (err_stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0]  gnt_q[$];
    logic [AW-1:0] addr_q[$];
    ret_t          ret_q[$];
    logic [AW-1:0] pend[$];

    logic ret_en       = 1'b1;
    logic toggle_ready = 1'b0;
    int   stray_reqs   = 0;
    int   stray_done   = 0;
    int   exp_stray    = 0;
    int   obs_stray    = 0;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {13'h0, a} ^ 32'h5A5A_0000;
        return {8{w}};
    endfunction

    function automatic logic [NL-1:0] lane_ref(input int lv);
        int m;
        m = (1 << (lv + 1)) - 1;
        return NL'(m);
    endfunction

    // Memory model: one-cycle read latency, optional ready toggling, address checks.
    initial begin
        logic [AW-1:0] a;
        logic [AW-1:0] held_addr;
        logic          held_valid;
        held_valid = 1'b0;
        held_addr  = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            mem_rvalid = 1'b0;
            if (ret_en && pend.size() > 0) begin
                a          = pend.pop_front();
                mem_rvalid = 1'b1;
                mem_rdata  = data_of(a);
            end else if (stray_reqs != stray_done) begin
                stray_done = stray_done + 1;
                mem_rvalid = 1'b1;
                mem_rdata  = data_of('0);
            end
            mem_ready = toggle_ready ? ~mem_ready : 1'b1;
            if (mem_req && held_valid) begin
                n_tests++;
                if (mem_addr !== held_addr) begin
                    n_fail++;
                    $display("FAIL addr_stable: got %h, required %h", mem_addr, held_addr);
                end
            end
            held_valid = 1'b0;
            if (mem_req && mem_ready) begin
                n_tests++;
                if (addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mem_addr_extra: got %h, required no issue", mem_addr);
                end else begin
                    a = addr_q.pop_front();
                    if (mem_addr !== a) begin
                        n_fail++;
                        $display("FAIL mem_addr: got %h, required %h", mem_addr, a);
                    end
                end
                pend.push_back(mem_addr);
            end else if (mem_req) begin
                held_valid = 1'b1;
                held_addr  = mem_addr;
            end
        end
    end

    // Output monitor: grants, return beats and stray pulses against the scoreboard.
    initial begin
        logic [N-1:0] g;
        ret_t         e;
        forever begin
            @(negedge clk);
            if (cl_gnt != '0) begin
                n_tests++;
                if (gnt_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL gnt_extra: got %b, required none", cl_gnt);
                end else begin
                    g = gnt_q.pop_front();
                    if (cl_gnt !== g) begin
                        n_fail++;
                        $display("FAIL gnt: got %b, required %b", cl_gnt, g);
                    end
                end
            end
            if (cl_rvalid != '0) begin
                n_tests++;
                if (ret_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rvalid_extra: got %b, required none", cl_rvalid);
                end else begin
                    e = ret_q.pop_front();
                    if (cl_rvalid !== e.rv || cl_rdata !== e.d || cl_rlast !== e.last ||
                        cl_rlane_en !== e.lane) begin
                        n_fail++;
                        $display("FAIL beat: got rv=%b last=%b lane=%h d=%h, required rv=%b last=%b lane=%h d=%h",
                                 cl_rvalid, cl_rlast, cl_rlane_en, cl_rdata, e.rv, e.last, e.lane, e.d);
                    end
                end
            end
            if (err_stray) begin
                n_tests++;
                if (obs_stray >= exp_stray) begin
                    n_fail++;
                    $display("FAIL stray_extra: got pulse %0d, required at most %0d", obs_stray + 1, exp_stray);
                end
                obs_stray = obs_stray + 1;
            end
        end
    end

    // Step one cycle; a granted client drops its request.
    task automatic tick();
        @(negedge clk);
        #2;
        cl_req = cl_req & ~cl_gnt;
    endtask

    task automatic set_client(input int c, input int addr, input int len, input int lv);
        cl_addr[c*AW +: AW]       = AW'(addr);
        cl_len[c*LW +: LW]        = LW'(len);
        cl_last_valid[c*LW +: LW] = LW'(lv);
    endtask

    task automatic push_burst(input int c, input int addr, input int len, input int lv);
        ret_t          e;
        logic [AW-1:0] a;
        gnt_q.push_back(N'(1) << c);
        for (int i = 0; i <= len; i++) begin
            a      = AW'(addr + i);
            addr_q.push_back(a);
            e.rv   = N'(1) << c;
            e.d    = data_of(a);
            e.last = (i == len);
            e.lane = (i == len) ? lane_ref(lv) : '1;
            ret_q.push_back(e);
        end
    endtask

    function automatic bit all_done();
        return (cl_req == '0) && !busy && (gnt_q.size() == 0) && (addr_q.size() == 0) &&
               (ret_q.size() == 0) && (pend.size() == 0) && (stray_reqs == stray_done) &&
               (obs_stray == exp_stray);
    endfunction

    task automatic wait_done(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (all_done()) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got busy=%b req=%b gnt_q=%0d addr_q=%0d ret_q=%0d, required all drained",
                     name, busy, cl_req, gnt_q.size(), addr_q.size(), ret_q.size());
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_tests++;
        if ({cl_gnt, cl_rvalid, cl_rlast, cl_rlane_en, mem_req, mem_addr, busy, err_stray} != '0 ||
            cl_rdata != '0) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b rv=%b last=%b lane=%h req=%b addr=%h busy=%b stray=%b, required all 0",
                     name, cl_gnt, cl_rvalid, cl_rlast, cl_rlane_en, mem_req, mem_addr, busy, err_stray);
        end
    endtask

    initial begin
        bit again;
        bit ok;
        rst           = 1'b1;
        arb_mode      = 1'b0;
        client_prio   = '0;
        cl_req        = '0;
        cl_addr       = '0;
        cl_len        = '0;
        cl_last_valid = '0;
        repeat (3) tick();
        check_outputs_zero("reset_state");
        rst = 1'b0;
        tick();

        // Single client 2, 4 beats, 8 valid lanes on the final beat.
        set_client(2, 'h100, 3, 7);
        push_burst(2, 'h100, 3, 7);
        cl_req[2] = 1'b1;
        wait_done("single", 100);

        // Fixed priority: client 4 in high class, then lowest index 1, then 2.
        client_prio = 5'b10000;
        set_client(1, 'h010, 1, 3);
        set_client(2, 'h020, 0, 0);
        set_client(4, 'h040, 2, 15);
        push_burst(4, 'h040, 2, 15);
        push_burst(1, 'h010, 1, 3);
        push_burst(2, 'h020, 0, 0);
        cl_req = 5'b10110;
        wait_done("fixed", 200);
        client_prio = '0;

        // Address wrap at the top of the word space.
        set_client(0, 'h7FFFE, 3, 15);
        push_burst(0, 'h7FFFE, 3, 15);
        cl_req[0] = 1'b1;
        wait_done("wrap", 100);

        // Ready toggling during issue.
        toggle_ready = 1'b1;
        set_client(3, 'h200, 2, 0);
        push_burst(3, 'h200, 2, 0);
        cl_req[3] = 1'b1;
        wait_done("stall", 100);
        toggle_ready = 1'b0;

        // Return with nothing outstanding while idle.
        exp_stray  = exp_stray + 1;
        stray_reqs = stray_reqs + 1;
        wait_done("stray_idle", 50);

        // Reset while draining; the late returns become strays.
        ret_en = 1'b0;
        set_client(1, 'h300, 3, 3);
        push_burst(1, 'h300, 3, 3);
        cl_req[1] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy && !mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got busy=%b req=%b, required DRAIN", busy, mem_req);
        end
        rst = 1'b1;
        tick();
        check_outputs_zero("reset_mid_drain");
        rst = 1'b0;
        ret_q.delete();
        exp_stray = exp_stray + pend.size();
        ret_en    = 1'b1;
        wait_done("late_stray", 50);
        push_burst(1, 'h300, 3, 3);
        cl_req[1] = 1'b1;
        wait_done("after_reset", 100);

        // Round-robin from pointer 0 with every client requesting; client 0 re-requests.
        rst = 1'b1;
        repeat (2) tick();
        rst      = 1'b0;
        arb_mode = 1'b1;
        tick();
        for (int c = 0; c < N; c++) begin
            set_client(c, 'h400 + c * 'h10, 1, c);
        end
        for (int c = 0; c < N; c++) begin
            push_burst(c, 'h400 + c * 'h10, 1, c);
        end
        push_burst(0, 'h400, 1, 0);
        cl_req = '1;
        again  = 1'b0;
        ok     = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!again && cl_gnt[0]) begin
                again     = 1'b1;
                cl_req[0] = 1'b1;
            end
            if (again && all_done()) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL rr_timeout: got gnt_q=%0d ret_q=%0d, required all drained", gnt_q.size(), ret_q.size());
        end

        n_tests++;
        if (obs_stray != exp_stray) begin
            n_fail++;
            $display("FAIL stray_total: got %0d, required %0d", obs_stray, exp_stray);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish within bound");
        $fatal(1, "global timeout");
    end

endmodule
